// File: rtl/frontend_ctrl.sv
// IF/ID front-end controller: fetch PC, imem handshake, one-entry skid buffer,
// IF/ID register, ID/EX valid bit and stall/redirect counters.
//
// state | meaning
// FETCH | free to issue a request at pcF
// WAIT  | one request granted, its response still to come
// DROP  | one request granted but redirected; its response is thrown away
module frontend_ctrl #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushD,
    input  logic             flushE,
    input  logic             br_selE,
    input  logic [XLEN-1:0]  br_target,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [XLEN-1:0]  pcF,
    output logic [XLEN-1:0]  pcD,
    output logic [31:0]      instrD,
    output logic             validD,
    output logic             validE,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] reqpc;
    logic            hold_vld;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic [XLEN-1:0] target;
    logic            accept;
    logic            rsp_take;
    logic            skid_load;

    assign target    = br_target & ~XLEN'(3);
    assign imem_addr = pcF;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= S_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: begin
                if (accept) begin
                    state_nxt = br_selE ? S_DROP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = S_FETCH;
                end else if (br_selE) begin
                    state_nxt = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_rvalid) begin
                    state_nxt = S_FETCH;
                end
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Request is masked during reset so the memory never sees a request while i_rst is high.
    always_comb begin
        imem_req  = (state == S_FETCH) && !stallF && !hold_vld && !i_rst;
        accept    = imem_req && imem_gnt;
        rsp_take  = (state == S_WAIT) && imem_rvalid && !br_selE;
        skid_load = rsp_take && stallD;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pcF   <= RESET_PC;
            reqpc <= '0;
        end else begin
            if (br_selE) begin
                pcF <= target;
            end else if (accept) begin
                pcF <= pcF + XLEN'(4);
            end
            if (accept) begin
                reqpc <= pcF;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_vld   <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= NOP;
        end else begin
            if (br_selE) begin
                hold_vld <= 1'b0;
            end else if (skid_load) begin
                hold_vld   <= 1'b1;
                skid_pc    <= reqpc;
                skid_instr <= imem_rdata;
            end else if (!flushD && !stallD && hold_vld) begin
                hold_vld <= 1'b0;
            end
        end
    end

    // A stalled response is captured by the skid buffer above, so holding here loses nothing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pcD    <= '0;
            instrD <= NOP;
            validD <= 1'b0;
        end else if (flushD) begin
            validD <= 1'b0;
            instrD <= NOP;
        end else if (stallD) begin
            validD <= validD;
        end else if (hold_vld) begin
            pcD    <= skid_pc;
            instrD <= skid_instr;
            validD <= 1'b1;
        end else if (rsp_take) begin
            pcD    <= reqpc;
            instrD <= imem_rdata;
            validD <= 1'b1;
        end else begin
            validD <= 1'b0;
            instrD <= NOP;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            validE <= 1'b0;
        end else begin
            validE <= (flushE || stallD) ? 1'b0 : validD;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (br_selE && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
